// File: rtl/restrict_skid_buffer.sv
// AXI-Stream register slice with registered s_tready and a one-entry skid register.
// Latency 1 cycle; a downstream stall parks one in-flight beat in skid, then s_tready drops.
module restrict_skid_buffer #(
  parameter bit GREEDY      = 1'b0,
  parameter int AXIS_DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXIS_DWIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [AXIS_DWIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready
);

  logic                   m_active;
  logic                   rdy_en;
  logic [AXIS_DWIDTH-1:0] sel_tdata;
  logic                   sel_tlast;
  logic                   sel_tvalid;
  logic [AXIS_DWIDTH-1:0] skid_tdata;
  logic                   skid_tlast;
  logic                   skid_tvalid;

  always_comb begin
    m_active = ~m_tvalid | m_tready;
    if (s_tready) begin
      sel_tdata  = s_tdata;
      sel_tlast  = s_tlast;
      sel_tvalid = s_tvalid;
    end else begin
      sel_tdata  = skid_tdata;
      sel_tlast  = skid_tlast;
      sel_tvalid = skid_tvalid;
    end
    // Greedy mode also reopens s_tready when the output drains with no upstream activity.
    if (GREEDY) rdy_en = m_active | s_tvalid;
    else        rdy_en = m_tready | s_tvalid;
  end

  // While s_tready is low the mux selects skid itself, so skid_tdata holds without an enable.
  always_ff @(posedge clk) begin
    skid_tdata <= sel_tdata;
    if (m_active) m_tdata <= sel_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_tvalid <= 1'b0;
      skid_tlast  <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      s_tready    <= 1'b0;
    end else begin
      skid_tvalid <= sel_tvalid & ~m_active;
      skid_tlast  <= sel_tlast & ~m_active;
      if (m_active) begin
        m_tvalid <= sel_tvalid;
        m_tlast  <= sel_tlast;
      end
      if (rdy_en) s_tready <= m_active;
    end
  end

endmodule

// File: tb/tb_restrict_skid_buffer.sv
// Scoreboard bench for restrict_skid_buffer; sel_g routes stimulus to the strict or greedy instance.
`timescale 1ns/1ps
module tb_restrict_skid_buffer;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel_g;
  logic [W-1:0] s_tdata;
  logic         s_tlast, s_tvalid, m_tready;
  logic         s_tready, m_tlast, m_tvalid;
  logic [W-1:0] m_tdata;

  logic         r0, r1, sv0, sv1, sl0, sl1, mr0, mr1;
  logic         sr0, sr1, ml0, ml1, mv0, mv1;
  logic [W-1:0] md0, md1;

  assign r0  = rst | sel_g;
  assign r1  = rst | ~sel_g;
  assign sv0 = s_tvalid & ~sel_g;
  assign sv1 = s_tvalid & sel_g;
  assign sl0 = s_tlast & ~sel_g;
  assign sl1 = s_tlast & sel_g;
  assign mr0 = m_tready & ~sel_g;
  assign mr1 = m_tready & sel_g;
  assign s_tready = sel_g ? sr1 : sr0;
  assign m_tvalid = sel_g ? mv1 : mv0;
  assign m_tlast  = sel_g ? ml1 : ml0;
  assign m_tdata  = sel_g ? md1 : md0;

  restrict_skid_buffer #(.GREEDY(1'b0), .AXIS_DWIDTH(W)) u_strict (
    .clk(clk), .rst(r0), .s_tdata(s_tdata), .s_tlast(sl0), .s_tvalid(sv0), .s_tready(sr0),
    .m_tdata(md0), .m_tlast(ml0), .m_tvalid(mv0), .m_tready(mr0));

  restrict_skid_buffer #(.GREEDY(1'b1), .AXIS_DWIDTH(W)) u_greedy (
    .clk(clk), .rst(r1), .s_tdata(s_tdata), .s_tlast(sl1), .s_tvalid(sv1), .s_tready(sr1),
    .m_tdata(md1), .m_tlast(ml1), .m_tvalid(mv1), .m_tready(mr1));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W:0] exp_q[$];
  bit         rnd_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int pending);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, pending=%0d, expected 0", name, pending);
  endtask

  // Offer one beat; expected output is recorded when the handshake is seen.
  task automatic send(input logic [W-1:0] d, input logic last);
    bit done = 1'b0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (s_tready) begin
        exp_q.push_back({last, d});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!done) timeout_fail("send", 1);
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) timeout_fail("drain", exp_q.size());
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit g, input logic mr);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = mr;
    sel_g    = g;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks protocol invariants.
  logic       prev_ok, prev_stall, prev_srdy, prev_svld;
  logic [W:0] prev_out;
  initial prev_ok = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      if (m_tlast) check("tlast_needs_tvalid", m_tvalid, 1);
      if (prev_ok && prev_stall)
        check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_out});
      if (prev_ok && prev_srdy && !s_tready)
        check("srdy_fall_after_svld", prev_svld, 1);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {m_tlast, m_tdata});
        end else begin
          check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        end
      end
      prev_ok    = 1'b1;
      prev_stall = m_tvalid & ~m_tready;
      prev_out   = {m_tlast, m_tdata};
      prev_srdy  = s_tready;
      prev_svld  = s_tvalid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel_g = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    rnd_done = 1'b0;

    // Reset state, then s_tready rises one edge after reset release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_s_tready", s_tready, 1);
    check("post_rst_m_tvalid", m_tvalid, 0);
    @(posedge clk);
    #1;

    // Streaming with one-cycle latency.
    send(32'h10, 1'b0);
    @(negedge clk);
    check("latency_vld", m_tvalid, 1);
    check("latency_dat", m_tdata, 32'h10);
    @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) send(32'h10 + i, i == 7);
    drain();

    // Downstream stall while 0xB is offered.
    fork
      begin
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b1);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (s_tvalid && s_tready && s_tdata == 32'hA) break;
        end
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stall_s_tready", s_tready, 0);
        check("stall_m_tvalid", m_tvalid, 1);
        check("stall_m_tdata", m_tdata, 32'hA);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();

    // Reset with output and skid both full.
    m_tready = 1'b0;
    send(32'h21, 1'b1);
    send(32'h22, 1'b0);
    @(negedge clk);
    check("full_s_tready", s_tready, 0);
    check("full_m_tlast", m_tlast, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_m_tlast", m_tlast, 0);
    check("midrst_s_tready", s_tready, 0);
    rst = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_beat", m_tvalid, 0);
    end
    @(posedge clk);
    #1;

    // Idle after reset with m_tready low: strict holds s_tready low, greedy raises it.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("strict_idle_s_tready", s_tready, 0);
    end
    do_reset(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("greedy_idle_s_tready", s_tready, 1);

    // Random valid/ready traffic on both instances.
    for (int g = 0; g < 2; g++) begin
      do_reset(g[0], 1'b0);
      @(posedge clk);
      #1;
      rnd_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
              @(posedge clk);
              #1;
            end
            send($urandom, $urandom_range(0, 3) == 0);
          end
          rnd_done = 1'b1;
        end
        begin
          logic nr;
          while (!rnd_done) begin
            @(posedge clk);
            #1;
            nr = ($urandom_range(0, 1) == 1);
            if (m_tready && !nr && !m_tvalid) nr = 1'b1;
            m_tready = nr;
          end
        end
      join
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
